// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: one requester's transaction port into mem_arbiter.
// master = requester side, slave = arbiter side.
interface mem_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 27
);
  logic                  req;
  logic                  wr;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  done;

  modport master (
    output req,
    output wr,
    output addr,
    output wdata,
    input  rdata,
    input  done
  );

  modport slave (
    input  req,
    input  wr,
    input  addr,
    input  wdata,
    output rdata,
    output done
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: two requesters share one single-port memory, 4 cycles/txn.
// Ports: clock, reset (async, active-high); m0/m1 requester buses
// (req/wr/addr/wdata in, rdata/done out); mem_address, mem_wr,
// mem_data (inout, memory drives it while mem_wr=0); busy.
// Macro MEM_ARBITER_RR_EN: round-robin grant; otherwise m0 has priority.
module mem_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 27
) (
  input  logic                  clock,
  input  logic                  reset,
  mem_arbiter_if.slave          m0,
  mem_arbiter_if.slave          m1,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_wr,
  inout  wire  [DATA_WIDTH-1:0] mem_data,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    CAPTURE,
    DONE
  } state_t;

  state_t state_q;
  state_t state_d;

  logic                  load;
  logic                  win;
  logic                  sel_q;
  logic                  wr_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata0_q;
  logic [DATA_WIDTH-1:0] rdata1_q;
  logic                  done0_q;
  logic                  done1_q;
  logic                  in_access;
  logic                  in_capture;

`ifdef MEM_ARBITER_RR_EN
  // Index of the requester granted most recently.
  logic last_q;
`endif

  // Winner among the current requests (only used in IDLE).
  always_comb begin
    win = 1'b0;
`ifdef MEM_ARBITER_RR_EN
    if (m0.req && m1.req) begin
      win = ~last_q;
    end else begin
      win = ~m0.req;
    end
`else
    win = ~m0.req;
`endif
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (m0.req || m1.req) begin
          state_d = ACCESS;
          load    = 1'b1;
        end
      end
      ACCESS:  state_d = CAPTURE;
      CAPTURE: state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Transaction latch; addr_q doubles as mem_address so the
  // bus holds its last value while idle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sel_q   <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (load) begin
      sel_q   <= win;
      wr_q    <= win ? m1.wr    : m0.wr;
      addr_q  <= win ? m1.addr  : m0.addr;
      wdata_q <= win ? m1.wdata : m0.wdata;
    end
  end

`ifdef MEM_ARBITER_RR_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_q <= 1'b1;
    end else if (load) begin
      last_q <= win;
    end
  end
`endif

  assign in_access  = (state_q == ACCESS);
  assign in_capture = (state_q == CAPTURE);

  // Read data and done pulses are registered at the edge
  // that ends CAPTURE, so done and rdata appear together.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rdata0_q <= '0;
      rdata1_q <= '0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
    end else begin
      done0_q <= in_capture && !sel_q;
      done1_q <= in_capture &&  sel_q;
      if (in_capture && !wr_q && !sel_q) begin
        rdata0_q <= mem_data;
      end
      if (in_capture && !wr_q && sel_q) begin
        rdata1_q <= mem_data;
      end
    end
  end

  // Decoded straight from the state register so an async
  // reset drops the strobe before the write edge arrives.
  assign mem_wr      = in_access && wr_q;
  assign mem_data    = mem_wr ? wdata_q : {DATA_WIDTH{1'bz}};
  assign mem_address = addr_q;
  assign busy        = (state_q != IDLE);

  assign m0.rdata = rdata0_q;
  assign m1.rdata = rdata1_q;
  assign m0.done  = done0_q;
  assign m1.done  = done1_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter with a
// behavioural single-port memory on mem_address/mem_wr/mem_data.
module tb_mem_arbiter;
  localparam int DW = 32;
  localparam int AW = 27;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  mem_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) m0_if ();
  mem_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) m1_if ();

  logic [AW-1:0] mem_address;
  logic          mem_wr;
  wire  [DW-1:0] mem_data;
  logic          busy;

  mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clock       (clock),
    .reset       (reset),
    .m0          (m0_if),
    .m1          (m1_if),
    .mem_address (mem_address),
    .mem_wr      (mem_wr),
    .mem_data    (mem_data),
    .busy        (busy)
  );

  logic [DW-1:0] mem [0:255];
  logic [DW-1:0] rd_q;
  logic          pl_en = 1'b0;
  logic [7:0]    pl_addr = '0;
  logic [DW-1:0] pl_data = '0;

  always @(posedge clock) begin
    if (pl_en) begin
      mem[pl_addr] <= pl_data;
    end else if (mem_wr) begin
      mem[mem_address[7:0]] <= mem_data;
    end
    rd_q <= mem[mem_address[7:0]];
  end

  assign mem_data = mem_wr ? {DW{1'bz}} : rd_q;

  int wr_cycles = 0;
  int m0_dones = 0;
  int m1_dones = 0;

  always @(negedge clock) begin
    if (mem_wr) wr_cycles <= wr_cycles + 1;
    if (m0_if.done) m0_dones <= m0_dones + 1;
    if (m1_if.done) m1_dones <= m1_dones + 1;
  end

  int checks = 0;
  int failures = 0;

  task automatic preload(input logic [7:0] a, input logic [DW-1:0] d);
    @(negedge clock);
    pl_en = 1'b1;
    pl_addr = a;
    pl_data = d;
    @(negedge clock);
    pl_en = 1'b0;
  endtask

  task automatic test_reset;
    #1;
    checks++;
    if (busy !== 1'b0 || mem_wr !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctl: busy=%b mem_wr=%b want 0 0", busy, mem_wr);
    end
    checks++;
    if (mem_address !== '0) begin
      failures++;
      $display("FAIL reset_addr: got %h want 0", mem_address);
    end
    checks++;
    if (m0_if.done !== 1'b0 || m1_if.done !== 1'b0) begin
      failures++;
      $display("FAIL reset_done: got %b%b want 00", m0_if.done, m1_if.done);
    end
    checks++;
    if (m0_if.rdata !== '0 || m1_if.rdata !== '0) begin
      failures++;
      $display("FAIL reset_rdata: got %h %h want 0 0",
               m0_if.rdata, m1_if.rdata);
    end
    preload(8'h20, 32'hA5A5A5A5);
    preload(8'h30, 32'h11111111);
    preload(8'h40, 32'h22222222);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_write;
    int w0;
    int d0;
    w0 = wr_cycles;
    d0 = m0_dones;
    @(negedge clock);
    m0_if.req = 1'b1;
    m0_if.wr = 1'b1;
    m0_if.addr = 27'h10;
    m0_if.wdata = 32'hDEADBEEF;
    @(negedge clock);
    checks++;
    if (mem_wr !== 1'b1 || mem_address !== 27'h10) begin
      failures++;
      $display("FAIL wr_access: mem_wr=%b addr=%h want 1 10",
               mem_wr, mem_address);
    end
    checks++;
    if (mem_data !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL wr_bus: got %h want deadbeef", mem_data);
    end
    @(negedge clock);
    checks++;
    if (mem_wr !== 1'b0 || m0_if.done !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL wr_capture: wr=%b done=%b busy=%b want 0 0 1",
               mem_wr, m0_if.done, busy);
    end
    @(negedge clock);
    checks++;
    if (m0_if.done !== 1'b1 || m1_if.done !== 1'b0) begin
      failures++;
      $display("FAIL wr_done_t3: got %b%b want 10", m0_if.done, m1_if.done);
    end
    m0_if.req = 1'b0;
    @(negedge clock);
    checks++;
    if (busy !== 1'b0 || m0_if.done !== 1'b0) begin
      failures++;
      $display("FAIL wr_idle: busy=%b done=%b want 0 0", busy, m0_if.done);
    end
    @(negedge clock);
    checks++;
    if (wr_cycles - w0 != 1 || m0_dones - d0 != 1) begin
      failures++;
      $display("FAIL wr_counts: wr=%0d done=%0d want 1 1",
               wr_cycles - w0, m0_dones - d0);
    end
    checks++;
    if (mem[8'h10] !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL wr_mem: got %h want deadbeef", mem[8'h10]);
    end
  endtask

  task automatic test_read;
    int w0;
    w0 = wr_cycles;
    @(negedge clock);
    m1_if.req = 1'b1;
    m1_if.wr = 1'b0;
    m1_if.addr = 27'h10;
    m1_if.wdata = 32'h0;
    @(negedge clock);
    checks++;
    if (mem_wr !== 1'b0 || mem_address !== 27'h10) begin
      failures++;
      $display("FAIL rd_access: mem_wr=%b addr=%h want 0 10",
               mem_wr, mem_address);
    end
    @(negedge clock);
    @(negedge clock);
    checks++;
    if (m1_if.done !== 1'b1 || m1_if.rdata !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL rd_done_t3: done=%b rdata=%h want 1 deadbeef",
               m1_if.done, m1_if.rdata);
    end
    checks++;
    if (m0_if.rdata !== 32'h0 || m0_if.done !== 1'b0) begin
      failures++;
      $display("FAIL rd_loser: rdata=%h done=%b want 0 0",
               m0_if.rdata, m0_if.done);
    end
    m1_if.req = 1'b0;
    @(negedge clock);
    @(negedge clock);
    checks++;
    if (wr_cycles != w0) begin
      failures++;
      $display("FAIL rd_no_write: got %0d want %0d", wr_cycles, w0);
    end
  endtask

  task automatic test_arbitration;
    int seen;
    int last_cyc;
    logic [3:0] exp_seq;
`ifdef MEM_ARBITER_RR_EN
    exp_seq = 4'b1010;
`else
    exp_seq = 4'b0000;
`endif
    seen = 0;
    last_cyc = -1;
    @(negedge clock);
    m0_if.req = 1'b1;
    m0_if.wr = 1'b0;
    m0_if.addr = 27'h30;
    m1_if.req = 1'b1;
    m1_if.wr = 1'b0;
    m1_if.addr = 27'h40;
    for (int c = 1; c <= 24 && seen < 4; c++) begin
      @(negedge clock);
      if (m0_if.done || m1_if.done) begin
        checks++;
        if (m1_if.done !== exp_seq[seen] || (m0_if.done && m1_if.done)) begin
          failures++;
          $display("FAIL arb_grant%0d: got m1=%b want m1=%b",
                   seen, m1_if.done, exp_seq[seen]);
        end
        checks++;
        if (c != (last_cyc < 0 ? 3 : last_cyc + 4)) begin
          failures++;
          $display("FAIL arb_cycle%0d: got %0d want %0d", seen, c,
                   last_cyc < 0 ? 3 : last_cyc + 4);
        end
        checks++;
        if (m0_if.done ? (m0_if.rdata !== 32'h11111111)
                       : (m1_if.rdata !== 32'h22222222)) begin
          failures++;
          $display("FAIL arb_data%0d: got %h %h want 11111111 22222222",
                   seen, m0_if.rdata, m1_if.rdata);
        end
        last_cyc = c;
        seen++;
      end
    end
    checks++;
    if (seen != 4) begin
      failures++;
      $display("FAIL arb_timeout: got %0d dones want 4", seen);
    end
    m0_if.req = 1'b0;
    seen = 0;
    for (int c = 1; c <= 8 && seen == 0; c++) begin
      @(negedge clock);
      if (m0_if.done || m1_if.done) begin
        seen = c;
        checks++;
        if (m1_if.done !== 1'b1 || c != 4) begin
          failures++;
          $display("FAIL arb_m1_after_drop: m1=%b cyc=%0d want 1 4",
                   m1_if.done, c);
        end
      end
    end
    checks++;
    if (seen == 0) begin
      failures++;
      $display("FAIL arb_drop_timeout: got none want m1 done");
    end
    m1_if.req = 1'b0;
    @(negedge clock);
    @(negedge clock);
  endtask

  task automatic test_reset_abort;
    int d1;
    int seen;
    @(negedge clock);
    m1_if.req = 1'b1;
    m1_if.wr = 1'b1;
    m1_if.addr = 27'h20;
    m1_if.wdata = 32'h12345678;
    @(negedge clock);
    checks++;
    if (mem_wr !== 1'b1) begin
      failures++;
      $display("FAIL abort_in_access: mem_wr=%b want 1", mem_wr);
    end
    d1 = m1_dones;
    reset = 1'b1;
    #1;
    checks++;
    if (mem_wr !== 1'b0 || busy !== 1'b0 || mem_address !== '0) begin
      failures++;
      $display("FAIL abort_regs: wr=%b busy=%b addr=%h want 0 0 0",
               mem_wr, busy, mem_address);
    end
    checks++;
    if (m0_if.rdata !== '0 || m1_if.rdata !== '0 ||
        m0_if.done !== 1'b0 || m1_if.done !== 1'b0) begin
      failures++;
      $display("FAIL abort_outs: rd %h %h done %b%b want 0 0 00",
               m0_if.rdata, m1_if.rdata, m0_if.done, m1_if.done);
    end
    repeat (3) @(negedge clock);
    checks++;
    if (mem[8'h20] !== 32'hA5A5A5A5 || m1_dones != d1) begin
      failures++;
      $display("FAIL abort_no_write: mem=%h dones=%0d want a5a5a5a5 %0d",
               mem[8'h20], m1_dones, d1);
    end
    reset = 1'b0;
    seen = 0;
    for (int c = 1; c <= 8 && seen == 0; c++) begin
      @(negedge clock);
      if (m1_if.done) seen = c;
    end
    checks++;
    if (seen != 3) begin
      failures++;
      $display("FAIL rearb_latency: got cycle %0d want 3", seen);
    end
    m1_if.req = 1'b0;
    @(negedge clock);
    checks++;
    if (mem[8'h20] !== 32'h12345678) begin
      failures++;
      $display("FAIL rearb_mem: got %h want 12345678", mem[8'h20]);
    end
  endtask

  task automatic test_back_to_back;
    int w0;
    int d0;
    int seen;
    w0 = wr_cycles;
    d0 = m0_dones;
    seen = 0;
    @(negedge clock);
    m0_if.req = 1'b1;
    m0_if.wr = 1'b1;
    m0_if.addr = 27'h50;
    m0_if.wdata = 32'h55555555;
    for (int c = 1; c <= 12 && seen < 2; c++) begin
      @(negedge clock);
      if (mem_wr) begin
        checks++;
        if (mem_data !== m0_if.wdata) begin
          failures++;
          $display("FAIL b2b_bus: got %h want %h", mem_data, m0_if.wdata);
        end
      end
      if (m0_if.done) begin
        checks++;
        if (c != (seen == 0 ? 3 : 7)) begin
          failures++;
          $display("FAIL b2b_cycle%0d: got %0d want %0d",
                   seen, c, seen == 0 ? 3 : 7);
        end
        seen++;
        m0_if.addr = 27'h51;
        m0_if.wdata = 32'h66666666;
        if (seen == 2) m0_if.req = 1'b0;
      end
    end
    repeat (4) @(negedge clock);
    checks++;
    if (wr_cycles - w0 != 2 || m0_dones - d0 != 2) begin
      failures++;
      $display("FAIL b2b_counts: wr=%0d done=%0d want 2 2",
               wr_cycles - w0, m0_dones - d0);
    end
    checks++;
    if (mem[8'h50] !== 32'h55555555 || mem[8'h51] !== 32'h66666666) begin
      failures++;
      $display("FAIL b2b_mem: got %h %h want 55555555 66666666",
               mem[8'h50], mem[8'h51]);
    end
  endtask

  initial begin
    m0_if.req = 1'b0;
    m0_if.wr = 1'b0;
    m0_if.addr = '0;
    m0_if.wdata = '0;
    m1_if.req = 1'b0;
    m1_if.wr = 1'b0;
    m1_if.addr = '0;
    m1_if.wdata = '0;
    test_reset();
    test_write();
    test_read();
    test_arbitration();
    test_reset_abort();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of memory word and all data ports.
REQ-002 Parameter ADDR_WIDTH, default 27, width of memory word address and all address ports.
REQ-003 Port clock  input  1  single clock; all state changes on posedge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Ports m0_req/m1_req  input  1  requester N transaction request, held high until mN_done.
REQ-006 Ports m0_wr/m1_wr  input  1  1 = write, 0 = read; held stable while mN_req high.
REQ-007 Ports m0_addr/m1_addr  input  ADDR_WIDTH  word address; held stable while mN_req high.
REQ-008 Ports m0_wdata/m1_wdata  input  DATA_WIDTH  write data; held stable while mN_req high.
REQ-009 Ports m0_rdata/m1_rdata  output  DATA_WIDTH  registered read data, valid when mN_done high.
REQ-010 Ports m0_done/m1_done  output  1  one-cycle completion pulse to requester N.
REQ-011 Port mem_address  output  ADDR_WIDTH  address to the single-port memory.
REQ-012 Port mem_wr  output  1  memory write strobe; memory drives mem_data whenever mem_wr=0.
REQ-013 Port mem_data  inout  DATA_WIDTH  shared memory data bus.
REQ-014 Port busy  output  1  high in every state except IDLE.

Function
REQ-015 FSM states: IDLE, ACCESS, CAPTURE, DONE; transitions IDLE->ACCESS (any req), ACCESS->CAPTURE, CAPTURE->DONE, DONE->IDLE, all unconditional except IDLE.
REQ-016 In IDLE with any req high, arbiter latches winner index, its wr, addr, wdata at posedge and enters ACCESS.
REQ-017 In ACCESS, mem_address = latched addr and mem_wr = latched wr; the memory performs the write or latches read data at the posedge ending ACCESS.
REQ-018 mem_wr SHALL be 0 in every state other than ACCESS.
REQ-019 mem_data driven with latched wdata only in ACCESS with latched wr=1; high impedance otherwise (no bus contention with memory read drive).
REQ-020 In CAPTURE, mem_address holds latched addr; for reads, mem_data is sampled into the winner's mN_rdata at the posedge ending CAPTURE; the loser's rdata is unchanged; writes leave both rdata unchanged.
REQ-021 In DONE, winner's mN_done = 1 (registered), loser's = 0; req inputs ignored; requester may drop req or change its request after this cycle.
REQ-022 Latency: req first sampled at posedge T -> mN_done high in cycle T+3; one transaction per 4 cycles maximum throughput.
REQ-023 Outside ACCESS/CAPTURE, mem_address holds its last value (no toggling while idle).
REQ-024 A req rising while another transaction is in flight waits; no request is dropped.

Reset
REQ-025 On reset assertion, immediately: state=IDLE, mem_wr=0, mem_data released to Z, mem_address=0, m0/m1_done=0, m0/m1_rdata=0, busy=0, round-robin pointer=1 (m0 favored next).
REQ-026 Reset during ACCESS before the posedge completes the write: write SHALL NOT occur; no done pulse issued for an aborted transaction.
REQ-027 After reset release, pending requests are re-arbitrated from IDLE.

Configuration
REQ-028 Macro MEM_ARBITER_RR_EN defined: round-robin; when both req high in IDLE, grant goes to the requester not granted last; pointer updated on each grant.
REQ-029 MEM_ARBITER_RR_EN undefined: fixed priority, m0 always wins simultaneous requests; pointer logic absent.

Verification
REQ-030 Reset, m0 write addr=0x10 data=0xDEADBEEF -> mem_wr=1 exactly one cycle (ACCESS), m0_done at T+3, memory[0x10]=0xDEADBEEF.
REQ-031 m1 read addr=0x10 after REQ-030 -> m1_rdata=0xDEADBEEF with m1_done at T+3, mem_wr stays 0, m0_rdata unchanged.
REQ-032 m0 and m1 both request reads continuously with RR_EN -> grants alternate m0,m1,m0,m1; done pulses every 4 cycles; without RR_EN -> m0 only until it drops req.
REQ-033 Assert reset mid-ACCESS of m1 write to 0x20 data=0x12345678 -> memory[0x20] unchanged, no m1_done, all outputs at reset values immediately.
REQ-034 m0 holds req through DONE and immediately issues next request -> exactly one done per transaction, no duplicate access, mem_data never driven while mem_wr=0.
